// File: rtl/regfile_pkg.sv
// Shared defaults and types for the decode-stage register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int RF_WIDTH  = 64;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  typedef logic [$clog2(RF_DEPTH)-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]         rf_data_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: DEPTH:1 select with zero/out-of-range masking.
// Latency: zero cycles from rd_addr (and from the write port when bypass is built in).
// Backpressure: none; a read is always answered.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = DEPTH - 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] entries,
  input  logic [AW-1:0]               rd_addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                        wr_act,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
`endif
  output logic [WIDTH-1:0]            rd_data
);

  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] ZERO_L  = AW'(ZERO_REG);

  logic rd_ok;

  assign rd_ok = (rd_addr != ZERO_L) && ({1'b0, rd_addr} < DEPTH_L);

  // Select the addressed entry, masked to zero for the zero register and
  // unbacked addresses; an accepted same-cycle write overrides when bypassing.
  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      rd_data = entries[rd_addr];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_act already excludes reset, the zero register and out-of-range writes.
    if (wr_act && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/regfile_nrw.sv
// Multi-read, single-write register file with a hardwired zero register
// (optional write-through bypass built when REGFILE_BYPASS_EN is defined).
// Latency: write visible one edge later; reads combinational. Backpressure: none.
module regfile_nrw
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = DEPTH - 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data
);

  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] ZERO_L  = AW'(ZERO_REG);

  logic                         wr_act;
  logic [DEPTH-1:0][WIDTH-1:0]  entries;

  // A write only counts outside reset and when it targets a real, writable entry.
  assign wr_act = wr_en && !reset && (wr_addr != ZERO_L) && ({1'b0, wr_addr} < DEPTH_L);

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    if (e == ZERO_REG) begin : g_zero
      assign entries[e] = '0;
    end else begin : g_flop
      logic             sel;
      logic [WIDTH-1:0] q;

      // One-hot write enable for this entry.
      assign sel = wr_act && (wr_addr == AW'(e));

      // Entry storage: reset clears, an enabled write loads, otherwise hold.
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (sel) begin
          q <= wr_data;
        end
      end

      assign entries[e] = q;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .entries  (entries),
      .rd_addr  (rd_addr[p]),
`ifdef REGFILE_BYPASS_EN
      .wr_act   (wr_act),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
`endif
      .rd_data  (rd_data[p])
    );
  end

endmodule

// File: tb/tb_regfile_nrw.sv
// Randomised and directed bench for regfile_nrw against an array reference model.
// Covers the default build and a WIDTH=32/DEPTH=16/NUM_RD=3 instance.
// Stimulus is driven on the falling edge and checked 1 time unit later.
module tb_regfile_nrw;

  logic clk;

  // Default configuration instance
  logic                 a_reset, a_wr_en;
  logic [4:0]           a_wr_addr;
  logic [63:0]          a_wr_data;
  logic [1:0][4:0]      a_rd_addr;
  logic [1:0][63:0]     a_rd_data;

  // Parameter sweep instance
  logic                 b_reset, b_wr_en;
  logic [3:0]           b_wr_addr;
  logic [31:0]          b_wr_data;
  logic [2:0][3:0]      b_rd_addr;
  logic [2:0][31:0]     b_rd_data;

  logic [63:0] ma [32];
  logic [31:0] mb [16];

  int n_chk = 0;
  int n_err = 0;

  regfile_nrw u_dut_a (
    .clk     (clk),
    .reset   (a_reset),
    .wr_en   (a_wr_en),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .rd_addr (a_rd_addr),
    .rd_data (a_rd_data)
  );

  regfile_nrw #(.WIDTH(32), .DEPTH(16), .NUM_RD(3)) u_dut_b (
    .clk     (clk),
    .reset   (b_reset),
    .wr_en   (b_wr_en),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Expected read value of the default instance during the current cycle.
  function automatic logic [63:0] exp_a(input int ra, input logic rst, input logic we,
                                        input int wa, input logic [63:0] wd);
    if (ra == 31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && wa == ra) return wd;
`endif
    return ma[ra];
  endfunction

  function automatic logic [63:0] exp_b(input int ra, input logic rst, input logic we,
                                        input int wa, input logic [31:0] wd);
    if (ra == 15) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && wa == ra) return {32'd0, wd};
`endif
    return {32'd0, mb[ra]};
  endfunction

  // One clock cycle on the default instance: drive, check reads, update model at the edge.
  task automatic cyc_a(input string tag, input logic rst, input logic we, input int wa,
                       input logic [63:0] wd, input int ra0, input int ra1);
    a_reset      = rst;
    a_wr_en      = we;
    a_wr_addr    = wa[4:0];
    a_wr_data    = wd;
    a_rd_addr[0] = ra0[4:0];
    a_rd_addr[1] = ra1[4:0];
    #1;
    check({tag, "/p0"}, a_rd_data[0], exp_a(ra0, rst, we, wa, wd));
    check({tag, "/p1"}, a_rd_data[1], exp_a(ra1, rst, we, wa, wd));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) ma[i] = 64'd0;
    end else if (we && wa != 31) begin
      ma[wa] = wd;
    end
    @(negedge clk);
  endtask

  task automatic cyc_b(input string tag, input logic rst, input logic we, input int wa,
                       input logic [31:0] wd, input int ra0, input int ra1, input int ra2);
    int ra [3];
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    b_reset   = rst;
    b_wr_en   = we;
    b_wr_addr = wa[3:0];
    b_wr_data = wd;
    for (int p = 0; p < 3; p++) b_rd_addr[p] = ra[p][3:0];
    #1;
    for (int p = 0; p < 3; p++)
      check($sformatf("%s/p%0d", tag, p), {32'd0, b_rd_data[p]}, exp_b(ra[p], rst, we, wa, wd));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) mb[i] = 32'd0;
    end else if (we && wa != 15) begin
      mb[wa] = wd;
    end
    @(negedge clk);
  endtask

  initial begin
    a_reset = 1'b1; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
    b_reset = 1'b1; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
    for (int i = 0; i < 32; i++) ma[i] = 64'd0;
    for (int i = 0; i < 16; i++) mb[i] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    b_reset = 1'b0;

    // Reset clears everything and beats a simultaneous write.
    cyc_a("pre_rst_wr", 0, 1, 3, 64'h55, 3, 0);
    cyc_a("rst_wr",     1, 1, 3, 64'hAA, 3, 30);
    cyc_a("post_rst",   0, 0, 0, 64'h0, 0, 3);
    cyc_a("post_rst30", 0, 0, 0, 64'h0, 30, 3);
    check("post_rst_lit", a_rd_data[1], 64'd0);

    // Basic write then read on both ports.
    cyc_a("wr5",   0, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 1);
    cyc_a("rd5",   0, 0, 0, 64'h0, 5, 5);
    a_rd_addr[0] = 5'd5;
    #1;
    check("rd5_lit", a_rd_data[0], 64'h0123_4567_89AB_CDEF);
    @(negedge clk);

    // Zero register ignores writes, same cycle and after.
    cyc_a("wr31",  0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
    cyc_a("rd31",  0, 0, 0, 64'h0, 31, 5);

    // Same-cycle write/read hazard on address 7.
    cyc_a("wr7a",  0, 1, 7, 64'h11, 0, 0);
    cyc_a("haz7",  0, 1, 7, 64'h22, 7, 7);
    cyc_a("rd7",   0, 0, 0, 64'h0, 7, 31);

    // Port independence sweep.
    for (int i = 0; i <= 30; i++) cyc_a("load", 0, 1, i, 64'h100 + 64'(i), 31, 31);
    for (int i = 0; i <= 30; i++) cyc_a("sweep", 0, 0, 0, 64'h0, i, 30 - i);

    // Random traffic including occasional mid-operation reset.
    for (int n = 0; n < 400; n++) begin
      cyc_a("rand_a", ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
            $urandom_range(0, 31), {$urandom, $urandom},
            $urandom_range(0, 31), $urandom_range(0, 31));
    end

    a_wr_en = 1'b0;
    a_reset = 1'b0;

    // Parameter sweep instance.
    cyc_b("b_zero",  0, 0, 0, 32'h0, 15, 15, 15);
    cyc_b("b_wr14",  0, 1, 14, 32'hDEAD_BEEF, 14, 15, 0);
    cyc_b("b_rd14",  0, 0, 0, 32'h0, 14, 14, 14);
    cyc_b("b_noen",  0, 0, 14, 32'h1234_5678, 14, 14, 14);
    cyc_b("b_hold",  0, 0, 0, 32'h0, 14, 14, 14);
    b_rd_addr[2] = 4'd14;
    #1;
    check("b_hold_lit", {32'd0, b_rd_data[2]}, 64'hDEAD_BEEF);
    @(negedge clk);
    cyc_b("b_wr15",  0, 1, 15, 32'hFFFF_FFFF, 15, 14, 15);
    for (int n = 0; n < 200; n++) begin
      cyc_b("rand_b", ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom,
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
